wb_int_ctrl: RTL and testbench

- Consumer end of the MEM/WB interrupt signals: Circular_ERET_To_WB, WB_NOINT_NextPC, WB_INT_PC_Choose and Circular_IE_Close_To_WB.
- Latches external interrupt requests, arbitrates them by priority, and takes an interrupt only at a legal WB instruction boundary.
- Saves the return PC in EPC, issues a one-cycle PC redirect to the fetch stage, and services ERET by redirecting back to EPC.
- Owns the global interrupt-enable (IE) bit.

---
 rtl/wb_int_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_wb_int_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_int_ctrl.sv
// wb_int_ctrl -- write-back stage interrupt controller.
//
// Purpose:
//   Latches rising edges on the external interrupt request lines and picks the
//   highest-priority pending source. Index 0 has the highest priority. An
//   interrupt is taken only at a legal write-back instruction boundary. On a
//   take the controller saves the return PC in EPC, clears IE, and issues a
//   one-cycle redirect to the handler. ERET redirects back to the saved EPC.
//
// Optional feature (macro NESTED_INT_EN):
//   Adds an EPC stack of depth NUM_SRC. While a source is in service, a
//   strictly higher-priority pending source may preempt it regardless of IE.
//   Each ERET pops one level of the stack. IE is set again only when the
//   stack becomes empty.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable                    WB advance; take/ERET/IE changes need enable=1
//   Int_Req[NUM_SRC]          synchronized interrupt requests (edge sensitive)
//   WB_NOINT_NextPC[32]       continuation PC, captured into EPC on a take
//   WB_INT_PC_Choose          WB instruction is an interruptible boundary
//   Circular_ERET_To_WB       ERET in WB
//   Circular_IE_Close_To_WB   WB instruction clears IE
//   Int_Redirect              one-cycle redirect pulse
//   Int_Redirect_PC[32]       redirect target (meaningful with Int_Redirect)
//   IE_out                    global interrupt enable
//   EPC_out[32]               top-of-stack EPC
//   Pending_out[NUM_SRC]      latched pending requests
//   In_Service[NUM_SRC]       sources currently in service
//
// state   | meaning
// IDLE    | no interrupt in service; takes allowed when IE=1
// SERVICE | at least one source in service; waiting for ERET
module wb_int_ctrl #(
  parameter int          NUM_SRC        = 3,
  parameter logic [31:0] HANDLER_BASE   = 32'h0000_0800,
  parameter logic [31:0] HANDLER_STRIDE = 32'h0000_0040
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] Int_Req,
  input  logic [31:0]        WB_NOINT_NextPC,
  input  logic               WB_INT_PC_Choose,
  input  logic               Circular_ERET_To_WB,
  input  logic               Circular_IE_Close_To_WB,
  output logic               Int_Redirect,
  output logic [31:0]        Int_Redirect_PC,
  output logic               IE_out,
  output logic [31:0]        EPC_out,
  output logic [NUM_SRC-1:0] Pending_out,
  output logic [NUM_SRC-1:0] In_Service
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] req_prev_q, req_prev_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic               ie_q, ie_d;
  logic [31:0]        epc_q, epc_d;
  logic               redir_q, redir_d;
  logic [31:0]        redir_pc_q, redir_pc_d;

  logic [NUM_SRC-1:0] pend_clr;
  logic [SRC_W-1:0]   pend_src;
  logic [31:0]        handler_pc;
  logic               take_ok;

`ifdef NESTED_INT_EN
  localparam int DEPTH_W = $clog2(NUM_SRC + 1);
  // epc_q is the top of stack; stack_q holds the older, preempted levels.
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [31:0]        stack_q [NUM_SRC];
  logic [31:0]        stack_d [NUM_SRC];
  logic [SRC_W-1:0]   svc_src;

  always_comb begin
    svc_src = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (in_service_q[i]) svc_src = SRC_W'(i);
    end
  end
`endif

  // Lowest set pending index wins.
  always_comb begin
    pend_src = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) pend_src = SRC_W'(i);
    end
  end

  assign handler_pc = HANDLER_BASE + (32'(pend_src) * HANDLER_STRIDE);

  // Common qualifiers for any take. ERET and IE-close both block a take in their cycle.
  assign take_ok = enable & WB_INT_PC_Choose & (|pending_q) &
                   ~Circular_ERET_To_WB & ~Circular_IE_Close_To_WB;

  always_comb begin
    state_d      = state_q;
    req_prev_d   = Int_Req;
    in_service_d = in_service_q;
    ie_d         = ie_q;
    epc_d        = epc_q;
    redir_d      = 1'b0;
    redir_pc_d   = redir_pc_q;
    pend_clr     = '0;
`ifdef NESTED_INT_EN
    depth_d      = depth_q;
    stack_d      = stack_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (take_ok && ie_q) begin
          epc_d                  = WB_NOINT_NextPC;
          ie_d                   = 1'b0;
          pend_clr[pend_src]     = 1'b1;
          in_service_d           = '0;
          in_service_d[pend_src] = 1'b1;
          redir_d                = 1'b1;
          redir_pc_d             = handler_pc;
          state_d                = SERVICE;
`ifdef NESTED_INT_EN
          depth_d                = DEPTH_W'(1);
`endif
        end else if (enable && Circular_ERET_To_WB) begin
          ie_d = 1'b1;
        end
      end
      SERVICE: begin
        if (enable && Circular_ERET_To_WB) begin
          redir_d    = 1'b1;
          redir_pc_d = epc_q;
`ifdef NESTED_INT_EN
          in_service_d[svc_src] = 1'b0;
          if (depth_q <= DEPTH_W'(1)) begin
            depth_d = '0;
            ie_d    = 1'b1;
            state_d = IDLE;
          end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
              if (i == int'(depth_q) - 2) epc_d = stack_q[i];
            end
            depth_d = depth_q - DEPTH_W'(1);
          end
`else
          in_service_d = '0;
          ie_d         = 1'b1;
          state_d      = IDLE;
`endif
        end
`ifdef NESTED_INT_EN
        // Preemption ignores IE; only strictly higher priority may nest.
        else if (take_ok && (pend_src < svc_src)) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (i == int'(depth_q) - 1) stack_d[i] = epc_q;
          end
          depth_d                = depth_q + DEPTH_W'(1);
          epc_d                  = WB_NOINT_NextPC;
          ie_d                   = 1'b0;
          pend_clr[pend_src]     = 1'b1;
          in_service_d[pend_src] = 1'b1;
          redir_d                = 1'b1;
          redir_pc_d             = handler_pc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (enable && Circular_IE_Close_To_WB) ie_d = 1'b0;

    // A new edge in the same cycle as a clear re-pends the source.
    pending_d = (pending_q & ~pend_clr) | (Int_Req & ~req_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_prev_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      ie_q         <= 1'b1;
      epc_q        <= '0;
      redir_q      <= 1'b0;
      redir_pc_q   <= '0;
`ifdef NESTED_INT_EN
      depth_q      <= '0;
      for (int i = 0; i < NUM_SRC; i++) stack_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_prev_q   <= req_prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      ie_q         <= ie_d;
      epc_q        <= epc_d;
      redir_q      <= redir_d;
      redir_pc_q   <= redir_pc_d;
`ifdef NESTED_INT_EN
      depth_q      <= depth_d;
      stack_q      <= stack_d;
`endif
    end
  end

  assign Int_Redirect    = redir_q;
  assign Int_Redirect_PC = redir_pc_q;
  assign IE_out          = ie_q;
  assign EPC_out         = epc_q;
  assign Pending_out     = pending_q;
  assign In_Service      = in_service_q;

endmodule

// File: tb/tb_wb_int_ctrl.sv
// Directed bench for wb_int_ctrl (NUM_SRC=3, default handler map).
// obs packs {Int_Redirect, IE_out, EPC_out, Pending_out, In_Service}.
module tb_wb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  Int_Req;
  logic [31:0] WB_NOINT_NextPC;
  logic        WB_INT_PC_Choose;
  logic        Circular_ERET_To_WB;
  logic        Circular_IE_Close_To_WB;
  logic        Int_Redirect;
  logic [31:0] Int_Redirect_PC;
  logic        IE_out;
  logic [31:0] EPC_out;
  logic [2:0]  Pending_out;
  logic [2:0]  In_Service;

  int checks = 0;
  int errors = 0;

  wire [39:0] obs = {Int_Redirect, IE_out, EPC_out, Pending_out, In_Service};

  wb_int_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .enable                  (enable),
    .Int_Req                 (Int_Req),
    .WB_NOINT_NextPC         (WB_NOINT_NextPC),
    .WB_INT_PC_Choose        (WB_INT_PC_Choose),
    .Circular_ERET_To_WB     (Circular_ERET_To_WB),
    .Circular_IE_Close_To_WB (Circular_IE_Close_To_WB),
    .Int_Redirect            (Int_Redirect),
    .Int_Redirect_PC         (Int_Redirect_PC),
    .IE_out                  (IE_out),
    .EPC_out                 (EPC_out),
    .Pending_out             (Pending_out),
    .In_Service              (In_Service)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; Int_Req = 3'b000; WB_NOINT_NextPC = 32'h0;
    WB_INT_PC_Choose = 1'b0; Circular_ERET_To_WB = 1'b0; Circular_IE_Close_To_WB = 1'b0;
    step(); step();
    checks++;
    if (obs !== {1'b0, 1'b1, 32'h0, 3'b000, 3'b000}) begin
      errors++; $display("FAIL reset_state got %h want %h", obs, {1'b0, 1'b1, 32'h0, 3'b000, 3'b000});
    end
    checks++;
    if (Int_Redirect_PC !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want 00000000", Int_Redirect_PC);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_take();
    Int_Req = 3'b010;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 32'h0, 3'b010, 3'b000}) begin
      errors++; $display("FAIL take_pend got %h want %h", obs, {1'b0, 1'b1, 32'h0, 3'b010, 3'b000});
    end
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0104;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h104, 3'b000, 3'b010}) begin
      errors++; $display("FAIL take_state got %h want %h", obs, {1'b1, 1'b0, 32'h104, 3'b000, 3'b010});
    end
    checks++;
    if (Int_Redirect_PC !== 32'h0000_0840) begin
      errors++; $display("FAIL take_pc got %h want 00000840", Int_Redirect_PC);
    end
    enable = 1'b0; WB_INT_PC_Choose = 1'b0;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h104, 3'b000, 3'b010}) begin
      errors++; $display("FAIL take_pulse got %h want %h", obs, {1'b0, 1'b0, 32'h104, 3'b000, 3'b010});
    end
  endtask

  task automatic test_eret();
    enable = 1'b1; Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h104, 3'b000, 3'b000}) begin
      errors++; $display("FAIL eret_state got %h want %h", obs, {1'b1, 1'b1, 32'h104, 3'b000, 3'b000});
    end
    checks++;
    if (Int_Redirect_PC !== 32'h0000_0104) begin
      errors++; $display("FAIL eret_pc got %h want 00000104", Int_Redirect_PC);
    end
    enable = 1'b0; Circular_ERET_To_WB = 1'b0;
    step();
    // Int_Req[1] has stayed high throughout: must not re-pend.
    checks++;
    if (obs !== {1'b0, 1'b1, 32'h104, 3'b000, 3'b000}) begin
      errors++; $display("FAIL eret_level got %h want %h", obs, {1'b0, 1'b1, 32'h104, 3'b000, 3'b000});
    end
    Int_Req = 3'b000;
    step();
  endtask

  task automatic test_priority();
    Int_Req = 3'b101;
    step();
    checks++;
    if (Pending_out !== 3'b101) begin
      errors++; $display("FAIL prio_pend got %b want 101", Pending_out);
    end
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0200;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h200, 3'b100, 3'b001}) begin
      errors++; $display("FAIL prio_take got %h want %h", obs, {1'b1, 1'b0, 32'h200, 3'b100, 3'b001});
    end
    checks++;
    if (Int_Redirect_PC !== 32'h0000_0800) begin
      errors++; $display("FAIL prio_pc got %h want 00000800", Int_Redirect_PC);
    end
    step(); step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h200, 3'b100, 3'b001}) begin
      errors++; $display("FAIL prio_hold got %h want %h", obs, {1'b0, 1'b0, 32'h200, 3'b100, 3'b001});
    end
    Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h200, 3'b100, 3'b000} || Int_Redirect_PC !== 32'h0000_0200) begin
      errors++; $display("FAIL prio_eret got %h pc %h want %h pc 00000200", obs, Int_Redirect_PC,
                         {1'b1, 1'b1, 32'h200, 3'b100, 3'b000});
    end
    Circular_ERET_To_WB = 1'b0; WB_NOINT_NextPC = 32'h0000_0300;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h300, 3'b000, 3'b100} || Int_Redirect_PC !== 32'h0000_0880) begin
      errors++; $display("FAIL prio_src2 got %h pc %h want %h pc 00000880", obs, Int_Redirect_PC,
                         {1'b1, 1'b0, 32'h300, 3'b000, 3'b100});
    end
    WB_INT_PC_Choose = 1'b0; Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h300, 3'b000, 3'b000} || Int_Redirect_PC !== 32'h0000_0300) begin
      errors++; $display("FAIL prio_ret2 got %h pc %h want %h pc 00000300", obs, Int_Redirect_PC,
                         {1'b1, 1'b1, 32'h300, 3'b000, 3'b000});
    end
    Circular_ERET_To_WB = 1'b0; enable = 1'b0; Int_Req = 3'b000;
    step();
  endtask

  task automatic test_blocking();
    Int_Req = 3'b001;
    step();
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; Circular_IE_Close_To_WB = 1'b1;
    WB_NOINT_NextPC = 32'h0000_0400;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h300, 3'b001, 3'b000}) begin
      errors++; $display("FAIL blk_close got %h want %h", obs, {1'b0, 1'b0, 32'h300, 3'b001, 3'b000});
    end
    Circular_IE_Close_To_WB = 1'b0;
    step(); step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h300, 3'b001, 3'b000}) begin
      errors++; $display("FAIL blk_ie0 got %h want %h", obs, {1'b0, 1'b0, 32'h300, 3'b001, 3'b000});
    end
    Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 32'h300, 3'b001, 3'b000}) begin
      errors++; $display("FAIL blk_eret_idle got %h want %h", obs, {1'b0, 1'b1, 32'h300, 3'b001, 3'b000});
    end
    Circular_ERET_To_WB = 1'b0;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h400, 3'b000, 3'b001} || Int_Redirect_PC !== 32'h0000_0800) begin
      errors++; $display("FAIL blk_take got %h pc %h want %h pc 00000800", obs, Int_Redirect_PC,
                         {1'b1, 1'b0, 32'h400, 3'b000, 3'b001});
    end
    WB_INT_PC_Choose = 1'b0; Circular_ERET_To_WB = 1'b1;
    step();
    Circular_ERET_To_WB = 1'b0; enable = 1'b0;
    step();
  endtask

  task automatic test_stall();
    Int_Req = 3'b010;
    step();
    // enable=0: IE-close and boundary must both be ignored.
    WB_INT_PC_Choose = 1'b1; Circular_IE_Close_To_WB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {1'b0, 1'b1, 32'h400, 3'b010, 3'b000}) begin
        errors++; $display("FAIL stall_en0 cyc %0d got %h want %h", i, obs, {1'b0, 1'b1, 32'h400, 3'b010, 3'b000});
      end
    end
    enable = 1'b1; WB_INT_PC_Choose = 1'b0; Circular_IE_Close_To_WB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== {1'b0, 1'b1, 32'h400, 3'b010, 3'b000}) begin
        errors++; $display("FAIL stall_nobnd cyc %0d got %h want %h", i, obs, {1'b0, 1'b1, 32'h400, 3'b010, 3'b000});
      end
    end
    WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0500;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h500, 3'b000, 3'b010} || Int_Redirect_PC !== 32'h0000_0840) begin
      errors++; $display("FAIL stall_take got %h pc %h want %h pc 00000840", obs, Int_Redirect_PC,
                         {1'b1, 1'b0, 32'h500, 3'b000, 3'b010});
    end
    enable = 1'b0; WB_INT_PC_Choose = 1'b0;
    step();
    checks++;
    if (Int_Redirect !== 1'b0) begin
      errors++; $display("FAIL stall_pulse got %b want 0", Int_Redirect);
    end
    enable = 1'b1; Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h500, 3'b000, 3'b000} || Int_Redirect_PC !== 32'h0000_0500) begin
      errors++; $display("FAIL stall_eret got %h pc %h want %h pc 00000500", obs, Int_Redirect_PC,
                         {1'b1, 1'b1, 32'h500, 3'b000, 3'b000});
    end
    Circular_ERET_To_WB = 1'b0; enable = 1'b0; Int_Req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    Int_Req = 3'b100;
    step();
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0600;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h600, 3'b000, 3'b100} || Int_Redirect_PC !== 32'h0000_0880) begin
      errors++; $display("FAIL mid_take got %h pc %h want %h pc 00000880", obs, Int_Redirect_PC,
                         {1'b1, 1'b0, 32'h600, 3'b000, 3'b100});
    end
    enable = 1'b0; WB_INT_PC_Choose = 1'b0; Int_Req = 3'b110;
    step();
    checks++;
    if (Pending_out !== 3'b010) begin
      errors++; $display("FAIL mid_pend got %b want 010", Pending_out);
    end
    rst = 1'b1; Int_Req = 3'b000;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 32'h0, 3'b000, 3'b000} || Int_Redirect_PC !== 32'h0) begin
      errors++; $display("FAIL mid_reset got %h pc %h want %h pc 00000000", obs, Int_Redirect_PC,
                         {1'b0, 1'b1, 32'h0, 3'b000, 3'b000});
    end
    rst = 1'b0;
    step();
  endtask

`ifdef NESTED_INT_EN
  task automatic test_nested();
    Int_Req = 3'b100;
    step();
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0700;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h700, 3'b000, 3'b100} || Int_Redirect_PC !== 32'h0000_0880) begin
      errors++; $display("FAIL nest_take2 got %h pc %h", obs, Int_Redirect_PC);
    end
    enable = 1'b0; WB_INT_PC_Choose = 1'b0; Int_Req = 3'b101;
    step();
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0704;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h704, 3'b000, 3'b101} || Int_Redirect_PC !== 32'h0000_0800) begin
      errors++; $display("FAIL nest_preempt got %h pc %h want %h pc 00000800", obs, Int_Redirect_PC,
                         {1'b1, 1'b0, 32'h704, 3'b000, 3'b101});
    end
    WB_INT_PC_Choose = 1'b0; Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h700, 3'b000, 3'b100} || Int_Redirect_PC !== 32'h0000_0704) begin
      errors++; $display("FAIL nest_eret1 got %h pc %h want %h pc 00000704", obs, Int_Redirect_PC,
                         {1'b1, 1'b0, 32'h700, 3'b000, 3'b100});
    end
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h700, 3'b000, 3'b000} || Int_Redirect_PC !== 32'h0000_0700) begin
      errors++; $display("FAIL nest_eret2 got %h pc %h want %h pc 00000700", obs, Int_Redirect_PC,
                         {1'b1, 1'b1, 32'h700, 3'b000, 3'b000});
    end
    Circular_ERET_To_WB = 1'b0; enable = 1'b0; Int_Req = 3'b000;
    step();
  endtask
`else
  task automatic test_no_nest();
    Int_Req = 3'b100;
    step();
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0700;
    step();
    enable = 1'b0; WB_INT_PC_Choose = 1'b0; Int_Req = 3'b101;
    step();
    enable = 1'b1; WB_INT_PC_Choose = 1'b1; WB_NOINT_NextPC = 32'h0000_0704;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h700, 3'b001, 3'b100}) begin
      errors++; $display("FAIL nonest_hold got %h want %h", obs, {1'b0, 1'b0, 32'h700, 3'b001, 3'b100});
    end
    WB_INT_PC_Choose = 1'b0; Circular_ERET_To_WB = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h700, 3'b001, 3'b000} || Int_Redirect_PC !== 32'h0000_0700) begin
      errors++; $display("FAIL nonest_eret got %h pc %h want %h pc 00000700", obs, Int_Redirect_PC,
                         {1'b1, 1'b1, 32'h700, 3'b001, 3'b000});
    end
    Circular_ERET_To_WB = 1'b0; enable = 1'b0; Int_Req = 3'b000;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_take();
    test_eret();
    test_priority();
    test_blocking();
    test_stall();
    test_reset_mid();
`ifdef NESTED_INT_EN
    test_nested();
`else
    test_no_nest();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
